// File: rtl/divider_mem_dispatch.sv
// divider_mem_dispatch: takes one batch of CDF operands from a scratch-memory
// read, fans them out to LANES divider units with a start pulse, collects each
// lane's quotient as it finishes (any order), then writes the results back as
// LINES consecutive scratch-memory lines separated by WT_GAP idle cycles.
//
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   enable               allows a new batch to be accepted
//   rd_data_rdy, rd_data scratch-memory read strobe and operands (lane i at [i*DATA_W +: DATA_W])
//   rd_ready             combinational: block can accept a batch
//   cdfval_todiv         latched operands presented to the dividers
//   div_start            one-cycle start pulse per lane
//   div_done, div_value  per-lane done (pulse or level) and quotient
//   sc_mem_wt_valid/line/data  line write strobe, line index, line data
//   batch_done           one-cycle pulse after the last line write
module divider_mem_dispatch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 8,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned WT_GAP = 2,
  localparam int unsigned BATCH_W    = LANES * DATA_W,
  localparam int unsigned LINES      = BATCH_W / LINE_W,
  localparam int unsigned LINE_IDX_W = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rd_data_rdy,
  input  logic [BATCH_W-1:0]    rd_data,
  output logic                  rd_ready,
  output logic [BATCH_W-1:0]    cdfval_todiv,
  output logic [LANES-1:0]      div_start,
  input  logic [LANES-1:0]      div_done,
  input  logic [BATCH_W-1:0]    div_value,
  output logic                  sc_mem_wt_valid,
  output logic [LINE_IDX_W-1:0] sc_mem_wt_line,
  output logic [LINE_W-1:0]     sc_mem_wt_data,
  output logic                  batch_done
);

  localparam int unsigned GAP_CNT_W = 4;
  localparam logic [LINE_IDX_W-1:0] LAST_LINE = LINE_IDX_W'(LINES - 1);
  localparam logic [GAP_CNT_W-1:0]  GAP_LAST  = GAP_CNT_W'((WT_GAP > 0) ? WT_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT_DIV, WRITE, GAP} state_t;

  state_t                  state_q, state_d;
  logic [LINE_IDX_W-1:0]   line_q, line_d;
  logic [GAP_CNT_W-1:0]    gap_q, gap_d;

  logic [LANES-1:0]        done_mask, done_mask_d;
  logic [BATCH_W-1:0]      result_q, result_d;
  logic [BATCH_W-1:0]      cdfval_d;
  logic [LANES-1:0]        div_start_d;
  logic                    wt_valid_d;
  logic [LINE_IDX_W-1:0]   wt_line_d;
  logic [LINE_W-1:0]       wt_data_d;
  logic                    batch_done_d;

  logic                    accept;
  logic [LANES-1:0]        capture;
  logic [LANES-1:0]        mask_merged;
  logic [31:0]             wr_base;

  assign rd_ready = enable & reset & (state_q == IDLE);
  assign accept   = rd_ready & rd_data_rdy;

  // div_start doubles as the start-cycle marker: dones seen then are stale
  assign capture     = (state_q == WAIT_DIV && div_start == '0) ? (div_done & ~done_mask) : '0;
  assign mask_merged = done_mask | capture;

  // FSM state and counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = WAIT_DIV;
      end
      WAIT_DIV: begin
        if (div_start == '0 && (&mask_merged)) begin
          state_d = WRITE;
          line_d  = '0;
        end
      end
      WRITE: begin
        if (line_q == LAST_LINE) begin
          state_d = IDLE;
        end else begin
          line_d = line_q + LINE_IDX_W'(1);
          if (WT_GAP > 0) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            state_d = WRITE;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = WRITE;
        else                   gap_d   = gap_q + GAP_CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs
  always_comb begin
    cdfval_d     = accept ? rd_data : cdfval_todiv;
    div_start_d  = accept ? {LANES{1'b1}} : '0;
    done_mask_d  = accept ? '0 : mask_merged;
    result_d     = result_q;
    for (int i = 0; i < LANES; i++) begin
      if (capture[i]) result_d[i*DATA_W +: DATA_W] = div_value[i*DATA_W +: DATA_W];
    end
    // Write data comes from result_d so a value captured on the final done
    // edge lands in the very first line write.
    wt_valid_d   = (state_d == WRITE);
    wr_base      = 32'(line_d) * 32'(LINE_W);
    wt_line_d    = wt_valid_d ? line_d : '0;
    wt_data_d    = wt_valid_d ? result_d[wr_base +: LINE_W] : '0;
    batch_done_d = (state_q == WRITE) && (line_q == LAST_LINE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cdfval_todiv    <= '0;
      div_start       <= '0;
      done_mask       <= '0;
      result_q        <= '0;
      sc_mem_wt_valid <= 1'b0;
      sc_mem_wt_line  <= '0;
      sc_mem_wt_data  <= '0;
      batch_done      <= 1'b0;
    end else begin
      cdfval_todiv    <= cdfval_d;
      div_start       <= div_start_d;
      done_mask       <= done_mask_d;
      result_q        <= result_d;
      sc_mem_wt_valid <= wt_valid_d;
      sc_mem_wt_line  <= wt_line_d;
      sc_mem_wt_data  <= wt_data_d;
      batch_done      <= batch_done_d;
    end
  end

endmodule
